fetch_queue: RTL and testbench

- Decoupling FIFO between the IF stage (PC register plus instruction memory) and the ID stage of the 5-stage pipeline processor.
- Each entry holds one fetched instruction word with its PC, PC+1 and taken-prediction bit.
- Upstream keeps fetching while the ID stage is held by a load-use interlock.
- A branch-mispredict flush empties the queue in one cycle.

---
 rtl/fetch_queue.sv | 105 ++++++++++
 tb/tb_fetch_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Decoupling FIFO between the IF and ID pipeline stages.
// Holds {pc, pc+1, prediction, instruction} entries; a flush empties it in one cycle.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 11,
    parameter int DW    = 32
) (
    input  logic                   w_clk,
    input  logic                   w_rst,
    input  logic                   w_flush,
    input  logic                   w_in_valid,
    output logic                   w_in_ready,
    input  logic [AW-1:0]          w_in_pc,
    input  logic [AW-1:0]          w_in_pc4,
    input  logic                   w_in_pr,
    input  logic [DW-1:0]          w_in_ir,
    output logic                   w_out_valid,
    input  logic                   w_out_ready,
    output logic [AW-1:0]          w_out_pc,
    output logic [AW-1:0]          w_out_pc4,
    output logic                   w_out_pr,
    output logic [DW-1:0]          w_out_ir,
    output logic [$clog2(DEPTH):0] w_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [DW-1:0] NOP_IR = DW'(32'h20);

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [AW-1:0] pc4;
        logic          pr;
        logic [DW-1:0] ir;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;

    // The occupancy count alone decides full/empty; pointers never compared.
    assign w_in_ready  = (count_q != CW'(DEPTH));
    assign w_out_valid = (count_q != '0);
    assign w_count     = count_q;

    assign push = w_in_valid  && w_in_ready  && !w_flush;
    assign pop  = w_out_valid && w_out_ready && !w_flush;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: entry storage has no reset; count gates every read, so stale data is never visible.
    always_ff @(posedge w_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{pc: w_in_pc, pc4: w_in_pc4, pr: w_in_pr, ir: w_in_ir};
        end
    end

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        w_out_pc  = '0;
        w_out_pc4 = '0;
        w_out_pr  = 1'b0;
        w_out_ir  = NOP_IR;
        if (w_out_valid) begin
            w_out_pc  = head.pc;
            w_out_pc4 = head.pc4;
            w_out_pr  = head.pr;
            w_out_ir  = head.ir;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed plan steps followed by random traffic,
// compared against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [AW-1:0] pc4;
        logic          pr;
        logic [DW-1:0] ir;
    } ent_t;

    logic          w_clk = 1'b0;
    logic          w_rst;
    logic          w_flush;
    logic          w_in_valid;
    logic          w_in_ready;
    logic [AW-1:0] w_in_pc;
    logic [AW-1:0] w_in_pc4;
    logic          w_in_pr;
    logic [DW-1:0] w_in_ir;
    logic          w_out_valid;
    logic          w_out_ready;
    logic [AW-1:0] w_out_pc;
    logic [AW-1:0] w_out_pc4;
    logic          w_out_pr;
    logic [DW-1:0] w_out_ir;
    logic [CW-1:0] w_count;

    int   n_checks = 0;
    int   n_pass   = 0;
    ent_t model_q[$];
    ent_t saved;

    fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .w_clk      (w_clk),
        .w_rst      (w_rst),
        .w_flush    (w_flush),
        .w_in_valid (w_in_valid),
        .w_in_ready (w_in_ready),
        .w_in_pc    (w_in_pc),
        .w_in_pc4   (w_in_pc4),
        .w_in_pr    (w_in_pr),
        .w_in_ir    (w_in_ir),
        .w_out_valid(w_out_valid),
        .w_out_ready(w_out_ready),
        .w_out_pc   (w_out_pc),
        .w_out_pc4  (w_out_pc4),
        .w_out_pr   (w_out_pr),
        .w_out_ir   (w_out_ir),
        .w_count    (w_count)
    );

    always #5 w_clk = ~w_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Compare every DUT output against what the reference queue implies.
    task automatic check_all(input string tag);
        ent_t h;
        h = '{pc: '0, pc4: '0, pr: 1'b0, ir: 32'h20};
        if (model_q.size() != 0) h = model_q[0];
        check({tag, ".count"}, 64'(w_count), 64'(model_q.size()));
        check({tag, ".out_valid"}, 64'(w_out_valid), 64'(model_q.size() != 0));
        check({tag, ".in_ready"}, 64'(w_in_ready), 64'(model_q.size() != DEPTH));
        check({tag, ".out_pc"}, 64'(w_out_pc), 64'(h.pc));
        check({tag, ".out_pc4"}, 64'(w_out_pc4), 64'(h.pc4));
        check({tag, ".out_pr"}, 64'(w_out_pr), 64'(h.pr));
        check({tag, ".out_ir"}, 64'(w_out_ir), 64'(h.ir));
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] pc, input logic pr,
                         input logic [DW-1:0] ir, input logic rdy, input logic fl);
        w_in_valid  = v;
        w_in_pc     = pc;
        w_in_pc4    = pc + AW'(1);
        w_in_pr     = pr;
        w_in_ir     = ir;
        w_out_ready = rdy;
        w_flush     = fl;
    endtask

    // Check current outputs, advance one clock, then update the model with what the edge did.
    task automatic step(input string tag);
        bit do_push, do_pop;
        ent_t e;
        check_all(tag);
        do_push = w_in_valid && (model_q.size() != DEPTH) && !w_flush;
        do_pop  = w_out_ready && (model_q.size() != 0) && !w_flush;
        e = '{pc: w_in_pc, pc4: w_in_pc4, pr: w_in_pr, ir: w_in_ir};
        @(posedge w_clk);
        #1;
        if (w_flush) model_q.delete();
        else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(e);
        end
    endtask

    initial begin
        w_rst = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge w_clk);
        #1;
        check_all("reset");
        w_rst = 1'b0;

        // Fill with ready low: pc 4 is offered while full and must be refused.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, AW'(i), i[0], 32'hA0 + 32'(i), 1'b0, 1'b0);
            step("fill");
        end
        check("fill.count4", 64'(w_count), 64'd4);
        check("fill.full_not_ready", 64'(w_in_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
            check("drain.order", 64'(w_out_pc), 64'(i));
            step("drain");
        end
        check("drain.empty", 64'(w_out_valid), 64'd0);

        // Latency: no bypass, entry shows up only after the edge.
        drive(1'b1, 11'h010, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
        check("lat.before_valid", 64'(w_out_valid), 64'd0);
        step("lat");
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        check("lat.after_pc", 64'(w_out_pc), 64'h010);
        check("lat.after_valid", 64'(w_out_valid), 64'd1);
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        step("lat_drain");

        // Streaming push+pop every cycle; pointers wrap past DEPTH.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, AW'(i), 1'b0, 32'hB0 + 32'(i), 1'b1, 1'b0);
            if (i > 0) check("stream.head", 64'(w_out_pc), 64'(i - 1));
            step("stream");
        end
        check("stream.count1", 64'(w_count), 64'd1);
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        step("stream_drain");

        // Flush with a concurrent push and pop offered: both discarded.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, AW'(i + 1), 1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
            step("pre_flush");
        end
        drive(1'b1, 11'h020, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1);
        step("flush");
        check("flush.count0", 64'(w_count), 64'd0);
        check("flush.ready", 64'(w_in_ready), 64'd1);
        drive(1'b1, 11'h021, 1'b0, 32'h1, 1'b1, 1'b1);
        step("flush_hold");
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);

        // Interlock: ID stalled while IF keeps fetching.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, AW'(i + 3), 1'b1, 32'hE0 + 32'(i), 1'b0, 1'b0);
            step("il_pre");
        end
        saved = model_q[0];
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, AW'(i + 5), 1'b0, 32'hE5 + 32'(i), 1'b0, 1'b0);
            step("interlock");
        end
        check("il.count4", 64'(w_count), 64'd4);
        check("il.head_pc", 64'(w_out_pc), 64'(saved.pc));
        check("il.head_pc4", 64'(w_out_pc4), 64'(saved.pc4));
        check("il.head_pr", 64'(w_out_pr), 64'(saved.pr));

        // Mid-run asynchronous reset with 3 entries: takes effect before any edge.
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        step("pre_rst");
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        #2 w_rst = 1'b1;
        #1;
        model_q.delete();
        check_all("async_rst");
        @(posedge w_clk);
        #1 w_rst = 1'b0;
        check_all("rst_release");

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom), 1'($urandom), $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
            step("rand");
        end
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        check_all("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
